// File: rtl/irq_router.sv
// ----------------------------------------------------------------------------
// irq_router
//
// Routes NumSrc raw peripheral interrupt lines onto the PLIC interrupt vector.
// Each source passes through a reset-to-0 synchroniser, an optional debounce
// filter, optional inversion, and level or edge handling, and is then masked
// and OR-ed into its PLIC index. irq_o is registered; edge_trigger_o is a
// constant derived from the parameters.
//
// Optional feature macro: IRQ_ROUTER_FILTER_EN
//   defined   - per-source debounce filter of FilterCycles cycles
//   undefined - synced value is used directly, FilterCycles is ignored
//
// Ports:
//   clk_i          in   1        single clock
//   rst_ni         in   1        asynchronous active-low reset
//   src_i          in   NumSrc   raw peripheral interrupt lines
//   mask_i         in   NumSrc   1 = suppress source (synchronous to clk_i)
//   irq_o          out  NumIrqs  to PLIC interrupts_i (bit 0 always 0)
//   edge_trigger_o out  NumIrqs  to PLIC edge_trigger_i (constant)
// ----------------------------------------------------------------------------
module irq_router #(
    parameter int                  NumSrc       = 4,
    parameter int                  NumIrqs      = 32,
    parameter int                  SyncStages   = 2,
    parameter logic [8*NumSrc-1:0] SrcIndex     = {8'd4, 8'd3, 8'd2, 8'd1},
    parameter logic [NumSrc-1:0]   SrcEdge      = '0,
    parameter logic [NumSrc-1:0]   SrcInvert    = '0,
    parameter int                  FilterCycles = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumSrc-1:0]  src_i,
    input  logic [NumSrc-1:0]  mask_i,
    output logic [NumIrqs-1:0] irq_o,
    output logic [NumIrqs-1:0] edge_trigger_o
);

    localparam int IdxW = (NumIrqs > 1) ? $clog2(NumIrqs) : 1;

    // ------------------------------------------------------------------
    // Elaboration-time helpers on the routing parameters
    // ------------------------------------------------------------------
    function automatic int src_idx(input int i);
        logic [8*NumSrc-1:0] tmp;
        tmp = SrcIndex >> (8 * i);
        return int'(tmp[7:0]);
    endfunction

    function automatic bit idx_valid(input int idx);
        return (idx >= 1) && (idx < NumIrqs);
    endfunction

    function automatic bit index_ok();
        for (int i = 0; i < NumSrc; i++) begin
            if (!idx_valid(src_idx(i))) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Sources sharing an index must agree on level/edge, otherwise the
    // PLIC cannot be told a single trigger type for that bit.
    function automatic bit edge_ok();
        for (int i = 0; i < NumSrc; i++) begin
            for (int j = i + 1; j < NumSrc; j++) begin
                if ((src_idx(i) == src_idx(j)) && (SrcEdge[i] != SrcEdge[j])) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [NumIrqs-1:0] edge_map();
        logic [NumIrqs-1:0] m;
        m = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (idx_valid(src_idx(i))) m[IdxW'(src_idx(i))] = m[IdxW'(src_idx(i))] | SrcEdge[i];
        end
        return m;
    endfunction

    localparam bit                 IndexOk = index_ok();
    localparam bit                 EdgeOk  = edge_ok();
    localparam logic [NumIrqs-1:0] EdgeMap = edge_map();

    if (!IndexOk) begin : g_err_index
        $error("irq_router: a SrcIndex entry lies outside 1..NumIrqs-1");
    end
    if (!EdgeOk) begin : g_err_edge
        $error("irq_router: sources sharing a PLIC index have mixed SrcEdge values");
    end
    if ((NumSrc < 1) || (NumSrc > 31)) begin : g_err_numsrc
        $error("irq_router: NumSrc must be in 1..31");
    end
    if (FilterCycles < 1) begin : g_err_filter
        $error("irq_router: FilterCycles must be at least 1");
    end

    assign edge_trigger_o = EdgeMap;

    // ------------------------------------------------------------------
    // Per-source pipeline: sync -> filter -> invert -> level/edge -> mask
    // ------------------------------------------------------------------
    logic [NumSrc-1:0] w_contrib;

    for (genvar i = 0; i < NumSrc; i++) begin : g_src
        logic w_synced;
        logic w_filt;
        logic w_act;

        if (SyncStages == 0) begin : g_nosync
            assign w_synced = src_i[i];
        end else begin : g_sync
            logic [SyncStages-1:0] r_sync;

            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge value of its neighbour; blocking here would
            // collapse the chain into a single stage.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= (r_sync << 1) | SyncStages'(src_i[i]);
                end
            end

            assign w_synced = r_sync[SyncStages-1];
        end

`ifdef IRQ_ROUTER_FILTER_EN
        begin : g_filter
            localparam int CntW = $clog2(FilterCycles + 1);
            logic            r_filt;
            logic [CntW-1:0] r_cnt;

            // r_cnt counts consecutive cycles where the synced value disagrees
            // with r_filt; the new value is accepted on the FilterCycles-th one.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_filt <= 1'b0;
                    r_cnt  <= '0;
                end else if (w_synced != r_filt) begin
                    if (r_cnt == CntW'(FilterCycles - 1)) begin
                        r_filt <= w_synced;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_filt = r_filt;
        end
`else
        assign w_filt = w_synced;
`endif

        assign w_act = w_filt ^ SrcInvert[i];

        if (SrcEdge[i]) begin : g_edge
            logic r_prev;

            // r_prev resets to the act value the pipeline produces while its
            // registers are cleared, so an idle-high active-low source does
            // not fire a spurious pulse when reset is released.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_prev <= SrcInvert[i];
                end else begin
                    r_prev <= w_act;
                end
            end

            // An edge seen while masked still updates r_prev, so it is lost.
            assign w_contrib[i] = w_act & ~r_prev & ~mask_i[i];
        end else begin : g_level
            assign w_contrib[i] = w_act & ~mask_i[i];
        end
    end

    // ------------------------------------------------------------------
    // Fan-in onto the PLIC vector
    // ------------------------------------------------------------------
    logic [NumIrqs-1:0] w_irq_next;
    logic [NumIrqs-1:0] r_irq;

    // NOTE: w_irq_next gets a full default before the loop; any path that
    // left a bit unassigned would otherwise infer a latch.
    always_comb begin
        w_irq_next = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (idx_valid(src_idx(i))) begin
                w_irq_next[IdxW'(src_idx(i))] = w_irq_next[IdxW'(src_idx(i))] | w_contrib[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq <= '0;
        end else begin
            r_irq <= w_irq_next;
        end
    end

    assign irq_o = r_irq;

endmodule
